// File: rtl/fillscreen.sv
// fillscreen: full-screen fill engine for the 160x120, 3-bit-colour VGA
// adapter. On start it emits one pixel write per clock in column-major order,
// colouring every pixel with its column index modulo 8 (vertical colour bars).
// The colour input is reserved and ignored.
module fillscreen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [7:0] LastX = 8'd159;
  localparam logic [6:0] LastY = 7'd119;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_done;

  // Busy / plot-enable flag; always equal to vga_plot.
  logic       mask;

  state_t     w_nextState;
  logic [7:0] w_nextX;
  logic [6:0] w_nextY;
  logic       w_nextPlot;
  logic       w_nextDone;

  // Folds the reserved colour input into a deliberately unused wire.
  logic       w_unused;
  assign w_unused = ^colour;

  // Next-state and next-output logic: walk y down each column, then step x.
  always_comb begin
    w_nextState = r_state;
    w_nextX     = r_x;
    w_nextY     = r_y;
    w_nextPlot  = 1'b0;
    w_nextDone  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextX     = 8'd0;
          w_nextY     = 7'd0;
          w_nextPlot  = 1'b1;
          w_nextState = S_FILL;
        end
      end
      S_FILL: begin
        if (r_y < LastY) begin
          w_nextY    = r_y + 7'd1;
          w_nextPlot = 1'b1;
        end else if (r_x < LastX) begin
          w_nextY    = 7'd0;
          w_nextX    = r_x + 8'd1;
          w_nextPlot = 1'b1;
        end else begin
          w_nextDone  = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextDone = 1'b1;
        if (!start) begin
          w_nextDone  = 1'b0;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; colour is registered together with x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
      mask     <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_x      <= w_nextX;
      r_y      <= w_nextY;
      r_colour <= w_nextX[2:0];
      r_plot   <= w_nextPlot;
      r_done   <= w_nextDone;
      mask     <= w_nextPlot;
    end
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;
  assign done       = r_done;

endmodule

// File: tb/tb_fillscreen.sv
// Testbench for fillscreen: a pixel-index reference model checked every cycle,
// a column-major ordering/coverage scoreboard, literal checkpoints and a
// randomized start/reset phase.
module tb_fillscreen;

  localparam int NumPix = 19200;

  logic       clk;
  logic       rst_n;
  logic [2:0] colour;
  logic       start;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: phase 0 idle, 1 busy, 2 done; mK is the pixel index.
  int mPhase = 0;
  int mK     = 0;
  int mHx    = 0;
  int mHy    = 0;

  int plotCount = 0;
  logic prevDone = 1'b0;

  fillscreen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .colour    (colour),
    .start     (start),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int expMask, input int expDone,
                             input int expX, input int expY, input int expPlot,
                             input int expColour);
    checkVal({tag, ".mask"},   int'(dut.mask),   expMask);
    checkVal({tag, ".done"},   int'(done),       expDone);
    checkVal({tag, ".x"},      int'(vga_x),      expX);
    checkVal({tag, ".y"},      int'(vga_y),      expY);
    checkVal({tag, ".plot"},   int'(vga_plot),   expPlot);
    checkVal({tag, ".colour"}, int'(vga_colour), expColour);
  endtask

  // Advance n clock edges, settling just after each edge, with random colour noise.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      colour = 3'($urandom);
    end
  endtask

  function automatic int expX();
    return (mPhase == 1) ? mK / 120 : mHx;
  endfunction

  function automatic int expY();
    return (mPhase == 1) ? mK % 120 : mHy;
  endfunction

  // Behavioural model of the fill sequence in terms of pixel index.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = 0;
      mK     = 0;
      mHx    = 0;
      mHy    = 0;
    end else begin
      case (mPhase)
        0: if (start) begin
             mPhase = 1;
             mK     = 0;
           end
        1: if (mK == NumPix - 1) begin
             mPhase = 2;
             mHx    = 159;
             mHy    = 119;
           end else begin
             mK = mK + 1;
           end
        default: if (!start) mPhase = 0;
      endcase
    end
  end

  // Per-cycle compare against the model plus ordering/coverage scoreboard.
  always @(negedge clk) begin
    checkVal("cyc.x",      int'(vga_x),      expX());
    checkVal("cyc.y",      int'(vga_y),      expY());
    checkVal("cyc.colour", int'(vga_colour), expX() % 8);
    checkVal("cyc.plot",   int'(vga_plot),   (mPhase == 1) ? 1 : 0);
    checkVal("cyc.mask",   int'(dut.mask),   (mPhase == 1) ? 1 : 0);
    checkVal("cyc.done",   int'(done),       (mPhase == 2) ? 1 : 0);
    if (!rst_n) begin
      plotCount = 0;
    end else begin
      if (vga_plot) begin
        checkVal("order", int'(vga_x) * 120 + int'(vga_y), plotCount);
        plotCount = plotCount + 1;
      end
      if (done && !prevDone) begin
        checkVal("coverage", plotCount, NumPix);
        plotCount = 0;
      end
    end
    prevDone = done;
  end

  // Watchdog so the run always ends.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by a randomized phase.
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    colour = 3'd0;

    applyStimulus(1);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);

    rst_n = 1'b1;
    start = 1'b1;
    applyStimulus(1);
    checkOutput("first", 1, 0, 0, 0, 1, 0);

    applyStimulus(NumPix);
    checkOutput("fillDone", 0, 1, 159, 119, 0, 7);

    start = 1'b0;
    applyStimulus(1);
    checkOutput("toIdle", 0, 0, 159, 119, 0, 7);

    start = 1'b1;
    applyStimulus(1);
    checkOutput("refill", 1, 0, 0, 0, 1, 0);
    applyStimulus(NumPix);
    checkOutput("refillDone", 0, 1, 159, 119, 0, 7);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("holdDone", 0, 1, 159, 119, 0, 7);
    end

    start = 1'b0;
    applyStimulus(1);
    start = 1'b1;
    applyStimulus(1);
    checkOutput("restart", 1, 0, 0, 0, 1, 0);

    applyStimulus(37 * 120 + 50);
    checkOutput("pix37_50", 1, 0, 37, 50, 1, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset", 0, 0, 0, 0, 0, 0);
    applyStimulus(1);
    rst_n = 1'b1;
    start = 1'b1;
    applyStimulus(1);
    checkOutput("afterReset", 1, 0, 0, 0, 1, 0);

    for (int i = 0; i < 24000; i++) begin
      @(posedge clk);
      #2;
      colour = 3'($urandom);
      start  = 1'($urandom);
      rst_n  = ($urandom_range(0, 49999) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    applyStimulus(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
